// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game engine.
// Directions, grid points, colours and the FSM state encoding.
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
    } point_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_INIT,
        S_WAIT,
        S_ERASE,
        S_MOVE,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [2:0] BLACK       = 3'b000;
    localparam logic [2:0] SNAKE_GREEN = 3'b010;

    function automatic dir_t opposite(input dir_t d);
        dir_t r;
        unique case (d)
            UP:      r = DOWN;
            DOWN:    r = UP;
            LEFT:    r = RIGHT;
            default: r = LEFT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_if.sv
// Pixel write port towards the VGA adapter.
// master: engine drives x, y, colour, plot; slave: adapter samples them.
interface snake_if;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot
    );
    modport slave (
        input vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/snake_body_buf.sv
// Circular store of snake segments with head push, tail pop and hit test.
// Ports: clk, rst, clr, push/push_pt, pop, head, tail, query -> hit.
module snake_body_buf
    import snake_pkg::*;
#(
    parameter int LEN = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   push,
    input  point_t push_pt,
    input  logic   pop,
    output point_t head,
    output point_t tail,
    input  point_t query,
    output logic   hit
);

    localparam int PW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [PW-1:0] LAST = PW'(LEN - 1);

    point_t          mem [LEN];
    logic [LEN-1:0]  valid;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   hd_ptr;
    logic [PW-1:0]   tl_ptr;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_pt;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid  <= '0;
            wr_ptr <= '0;
            hd_ptr <= '0;
            tl_ptr <= '0;
        end else begin
            if (pop) begin
                valid[tl_ptr] <= 1'b0;
                tl_ptr        <= inc(tl_ptr);
            end
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                hd_ptr        <= wr_ptr;
                wr_ptr        <= inc(wr_ptr);
            end
        end
    end

    assign head = mem[hd_ptr];
    assign tail = mem[tl_ptr];

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            if (valid[i] && (mem[i] == query)) hit = 1'b1;
        end
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game engine: clears the frame, draws the snake, advances per step.
// Ports: clk, rst, start, step, dir -> busy, done, moves, vga (pixel port).
module snake_engine
    import snake_pkg::*;
#(
    parameter int         GRID_W       = 160,
    parameter int         GRID_H       = 120,
    parameter int         LEN          = 8,
    parameter int         START_X      = 80,
    parameter int         START_Y      = 60,
    parameter logic [2:0] SNAKE_COLOUR = SNAKE_GREEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic [1:0]  dir,
    output logic        busy,
    output logic        done,
    output logic [15:0] moves,
    snake_if.master     vga
);

    localparam logic [7:0]        XL   = 8'(GRID_W - 1);
    localparam logic [6:0]        YL   = 7'(GRID_H - 1);
    localparam logic [7:0]        X0   = 8'(START_X - LEN + 1);
    localparam logic [6:0]        Y0   = 7'(START_Y);
    localparam logic [5:0]        NSEG = 6'(LEN);
    localparam logic signed [8:0] XMAX = 9'(GRID_W);
    localparam logic signed [7:0] YMAX = 8'(GRID_H);

    // Registered outputs; the *_n values are what the next cycle shows.
    state_t      state, state_n;
    logic [7:0]  x_q, x_n;
    logic [6:0]  y_q, y_n;
    logic [2:0]  col_q, col_n;
    logic        plot_q, plot_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;
    logic [15:0] moves_q, moves_n;
    dir_t        dir_q, dir_n;
    logic [5:0]  cnt_q, cnt_n;

    logic   clr, push, pop, hit, oob;
    point_t push_pt, head, tail, newpt;
    dir_t   want, ndir;
    logic signed [8:0] nx;
    logic signed [7:0] ny;

    snake_body_buf #(.LEN(LEN)) u_body (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .push    (push),
        .push_pt (push_pt),
        .pop     (pop),
        .head    (head),
        .tail    (tail),
        .query   (newpt),
        .hit     (hit)
    );

    // A request to reverse onto the neck keeps the current heading.
    assign want = dir_t'(dir);
    assign ndir = (want == opposite(dir_q)) ? dir_q : want;

    always_comb begin
        nx = $signed({1'b0, head.x});
        ny = $signed({1'b0, head.y});
        unique case (ndir)
            UP:      ny = ny - 8'sd1;
            DOWN:    ny = ny + 8'sd1;
            LEFT:    nx = nx - 9'sd1;
            default: nx = nx + 9'sd1;
        endcase
    end

    assign oob   = nx[8] || ny[7] || (nx >= XMAX) || (ny >= YMAX);
    assign newpt = '{x: nx[7:0], y: ny[6:0]};

    always_comb begin
        state_n = state;
        x_n     = x_q;
        y_n     = y_q;
        col_n   = col_q;
        plot_n  = 1'b0;
        busy_n  = busy_q;
        done_n  = 1'b0;
        moves_n = moves_q;
        dir_n   = dir_q;
        cnt_n   = cnt_q;
        clr     = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        push_pt = newpt;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_CLEAR;
                    busy_n  = 1'b1;
                    moves_n = '0;
                    dir_n   = RIGHT;
                    clr     = 1'b1;
                    plot_n  = 1'b1;
                    x_n     = '0;
                    y_n     = '0;
                    col_n   = BLACK;
                end
            end
            S_CLEAR: begin
                plot_n = 1'b1;
                if (x_q == XL && y_q == YL) begin
                    state_n = S_INIT;
                    x_n     = X0;
                    y_n     = Y0;
                    col_n   = SNAKE_COLOUR;
                    push    = 1'b1;
                    push_pt = '{x: X0, y: Y0};
                    cnt_n   = 6'd1;
                end else if (x_q == XL) begin
                    x_n = '0;
                    y_n = y_q + 7'd1;
                end else begin
                    x_n = x_q + 8'd1;
                end
            end
            S_INIT: begin
                if (cnt_q == NSEG) begin
                    state_n = S_WAIT;
                end else begin
                    plot_n  = 1'b1;
                    x_n     = x_q + 8'd1;
                    push    = 1'b1;
                    push_pt = '{x: x_q + 8'd1, y: y_q};
                    cnt_n   = cnt_q + 6'd1;
                end
            end
            S_WAIT: begin
                if (step) begin
                    state_n = S_ERASE;
                    plot_n  = 1'b1;
                    x_n     = tail.x;
                    y_n     = tail.y;
                    col_n   = BLACK;
                    pop     = 1'b1;
                end
            end
            S_ERASE: state_n = S_MOVE;
            S_MOVE: begin
                dir_n = ndir;
                if (oob || hit) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    state_n = S_DRAW;
                    plot_n  = 1'b1;
                    x_n     = newpt.x;
                    y_n     = newpt.y;
                    col_n   = SNAKE_COLOUR;
                    push    = 1'b1;
                    if (moves_q != 16'hFFFF) moves_n = moves_q + 16'd1;
                end
            end
            S_DRAW:  state_n = S_WAIT;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= BLACK;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            moves_q <= '0;
            dir_q   <= RIGHT;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            col_q   <= col_n;
            plot_q  <= plot_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            moves_q <= moves_n;
            dir_q   <= dir_n;
            cnt_q   <= cnt_n;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign moves          = moves_q;
    assign vga.vga_x      = x_q;
    assign vga.vga_y      = y_q;
    assign vga.vga_colour = col_q;
    assign vga.vga_plot   = plot_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine on an 8x6 grid (LEN=3 and LEN=5).
// Drives #1 after posedge, checks outputs in the same settled window.
module tb_snake_engine;
    import snake_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start_a = 0, step_a = 0;
    logic [1:0]  dir_a = 2'd2;
    logic        busy_a, done_a;
    logic [15:0] moves_a;

    logic        start_b = 0, step_b = 0;
    logic [1:0]  dir_b = 2'd2;
    logic        busy_b, done_b;
    logic [15:0] moves_b;

    snake_if vga_a ();
    snake_if vga_b ();

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    snake_engine #(
        .GRID_W(8), .GRID_H(6), .LEN(3),
        .START_X(4), .START_Y(3)
    ) dut_a (
        .clk(clk), .rst(rst),
        .start(start_a), .step(step_a), .dir(dir_a),
        .busy(busy_a), .done(done_a), .moves(moves_a),
        .vga(vga_a)
    );

    snake_engine #(
        .GRID_W(8), .GRID_H(6), .LEN(5),
        .START_X(4), .START_Y(3)
    ) dut_b (
        .clk(clk), .rst(rst),
        .start(start_b), .step(step_b), .dir(dir_b),
        .busy(busy_b), .done(done_b), .moves(moves_b),
        .vga(vga_b)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int p, input int x,
                                       input int y, input int c);
        logic [31:0] r;
        r = {13'd0, p[0], x[7:0], y[6:0], c[2:0]};
        return r;
    endfunction

    function automatic logic [31:0] pix(input int sel);
        if (sel == 0)
            return {13'd0, vga_a.vga_plot, vga_a.vga_x,
                    vga_a.vga_y, vga_a.vga_colour};
        return {13'd0, vga_b.vga_plot, vga_b.vga_x,
                vga_b.vga_y, vga_b.vga_colour};
    endfunction

    function automatic logic [31:0] plt(input int sel);
        return {31'd0, (sel == 0) ? vga_a.vga_plot : vga_b.vga_plot};
    endfunction

    function automatic logic [31:0] st(input int sel);
        if (sel == 0) return {14'd0, busy_a, done_a, moves_a};
        return {14'd0, busy_b, done_b, moves_b};
    endfunction

    // Status word layout: {busy, done, moves}.
    function automatic logic [31:0] mst(input int b, input int d,
                                        input int m);
        logic [31:0] r;
        r = {14'd0, b[0], d[0], m[15:0]};
        return r;
    endfunction

    task automatic do_step(input int sel, input logic [1:0] d,
                           input int ex, input int ey, input bit die,
                           input int hx, input int hy, input int mv);
        if (sel == 0) begin
            dir_a = d; step_a = 1'b1;
        end else begin
            dir_b = d; step_b = 1'b1;
        end
        tick();
        step_a = 1'b0;
        step_b = 1'b0;
        chk("erase", pix(sel), mk(1, ex, ey, 0));
        tick();
        chk("move_gap", plt(sel), 32'd0);
        tick();
        if (die) begin
            chk("die_noplot", plt(sel), 32'd0);
            chk("die_status", st(sel), mst(0, 1, mv));
            tick();
            chk("done_pulse", st(sel), mst(0, 0, mv));
        end else begin
            chk("draw", pix(sel), mk(1, hx, hy, 2));
            chk("draw_status", st(sel), mst(1, 0, mv));
            tick();
            chk("wait_noplot", plt(sel), 32'd0);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_pix_a", pix(0), mk(0, 0, 0, 0));
        chk("rst_st_a", st(0), mst(0, 0, 0));
        chk("rst_st_b", st(1), mst(0, 0, 0));
        rst = 1'b0;
        tick();

        // Clear and initial draw.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("busy_on", st(0), mst(1, 0, 0));
        for (int i = 0; i < 48; i++) begin
            chk("clear", pix(0), mk(1, i % 8, i / 8, 0));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("init", pix(0), mk(1, 2 + i, 3, 2));
            tick();
        end
        chk("wait0", plt(0), 32'd0);

        // Advance, reverse ignored, run off the right edge.
        do_step(0, 2'd2, 2, 3, 0, 5, 3, 1);
        do_step(0, 2'd1, 3, 3, 0, 6, 3, 2);
        do_step(0, 2'd2, 4, 3, 0, 7, 3, 3);
        do_step(0, 2'd2, 5, 3, 1, 0, 0, 3);

        // IDLE drops steps.
        step_a = 1'b1;
        tick();
        step_a = 1'b0;
        chk("idle_step", plt(0), 32'd0);
        tick();
        chk("idle_st", st(0), mst(0, 0, 3));

        // Reset in the middle of CLEAR.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("clear10", pix(0), mk(1, 1, 1, 0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_plot", plt(0), 32'd0);
        chk("rst_mid_st", st(0), mst(0, 0, 0));
        step_a = 1'b1;
        tick();
        step_a = 1'b0;
        chk("rst_step", plt(0), 32'd0);
        tick();
        chk("rst_step2", pix(0), mk(0, 0, 0, 0));

        // LEN=5: turn up, left, then down into the body.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 48; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("init_b", pix(1), mk(1, i, 3, 2));
            tick();
        end
        chk("wait_b", plt(1), 32'd0);
        do_step(1, 2'd0, 0, 3, 0, 4, 2, 1);
        do_step(1, 2'd1, 1, 3, 0, 3, 2, 2);
        do_step(1, 2'd3, 2, 3, 1, 0, 0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
